// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU placed between the ID/EX and EX/MEM pipeline registers.
//   It decodes ALUOP/function code itself and registers the result, flags and
//   illegal-op indication. Valid/ready handshakes are used on both sides.
//   Single-cycle ops have a latency of 1. MUL is an iterative shift-add unit
//   that takes DATA_WIDTH cycles. in_ready drops while the unit is busy or
//   while it is holding a result that has not been consumed, so the hazard
//   unit can stall upstream stages.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operation presented        in_ready   unit can accept this cycle
//   alu_op      ALUOP from control         func_code  A-type function code
//   op_a, op_b  operands (captured on accept)
//   out_valid   result registers valid     out_ready  downstream consumes result
//   result      primary result             result_hi  SWAP: A, MUL: high half, else 0
//   flag_zero   result == 0                flag_carry ADD carry-out / SUB borrow
//   op_illegal  accompanying op was undecodable
module alu_exec_unit #(
  parameter int DATA_WIDTH = 16,
  parameter bit MUL_ENABLE = 1'b1,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic [3:0]            func_code,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  op_illegal
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL_BUSY, S_HOLD} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [W-1:0]          r_result;
  logic [W-1:0]          r_result_hi;
  logic                  r_zero;
  logic                  r_carry;
  logic                  r_illegal;

  // Multiplier working registers (only meaningful while in S_MUL_BUSY)
  logic [2*W-1:0]        r_mcand;
  logic [W-1:0]          r_mplier;
  logic [2*W-1:0]        r_acc;

  logic [W:0]            w_sum;
  logic [W:0]            w_diff;
  logic [W-1:0]          w_res;
  logic [W-1:0]          w_hi;
  logic                  w_carry;
  logic                  w_illegal;
  logic                  w_is_mul;
  logic                  w_accept;
  logic [2*W-1:0]        w_addend;
  logic [2*W-1:0]        w_acc_nxt;

  // Combinational decode / single-cycle datapath
  always_comb begin
    w_sum     = {1'b0, op_a} + {1'b0, op_b};
    // Bit W of the widened difference is the borrow (A < B)
    w_diff    = {1'b0, op_a} - {1'b0, op_b};
    w_res     = w_sum[W-1:0];
    w_hi      = '0;
    w_carry   = w_sum[W];
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    if (alu_op == 4'b0001) begin
      case (func_code)
        4'b0000: ;
        4'b0001: begin
          w_res   = w_diff[W-1:0];
          w_carry = w_diff[W];
        end
        4'b0100: begin
          w_res   = '0;
          w_carry = 1'b0;
          if (MUL_ENABLE) w_is_mul  = 1'b1;
          else            w_illegal = 1'b1;
        end
        4'b1110: begin
          w_res   = op_b;
          w_carry = 1'b0;
        end
        4'b1111: begin
          w_res   = op_b;
          w_hi    = op_a;
          w_carry = 1'b0;
        end
        default: begin
          w_res     = '0;
          w_carry   = 1'b0;
          w_illegal = 1'b1;
        end
      endcase
    end else if (alu_op == 4'b1001) begin
      w_res   = op_a & op_b;
      w_carry = 1'b0;
    end else if (alu_op == 4'b1010) begin
      w_res   = op_a | op_b;
      w_carry = 1'b0;
    end
    // Any other alu_op falls through as ADD for address computation
  end

  // Shift-add step: add the shifted multiplicand when the current LSB is set
  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_addend;

  // HOLD drains and refills in the same cycle when downstream is ready
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid  = (r_state == S_HOLD);
  assign result     = r_result;
  assign result_hi  = r_result_hi;
  assign flag_zero  = r_zero;
  assign flag_carry = r_carry;
  assign op_illegal = r_illegal;

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= S_MUL_BUSY;
              r_cnt   <= CNT_WIDTH'(W);
            end else begin
              r_state     <= S_HOLD;
              r_result    <= w_res;
              r_result_hi <= w_hi;
              r_zero      <= (w_res == '0);
              r_carry     <= w_carry;
              r_illegal   <= w_illegal;
            end
          end else if ((r_state == S_HOLD) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_MUL_BUSY: begin
          r_cnt <= r_cnt - CNT_WIDTH'(1);
          // Last step: the accumulator update of this cycle is the product
          if (r_cnt == CNT_WIDTH'(1)) begin
            r_state     <= S_HOLD;
            r_result    <= w_acc_nxt[W-1:0];
            r_result_hi <= w_acc_nxt[2*W-1:W];
            r_zero      <= (w_acc_nxt[W-1:0] == '0);
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Multiplier datapath: operands captured on accept, shifted each busy cycle
  always_ff @(posedge clk) begin
    if (w_accept && w_is_mul) begin
      r_mcand  <= {{W{1'b0}}, op_a};
      r_mplier <= op_b;
      r_acc    <= '0;
    end else if (r_state == S_MUL_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [3:0]  func_code;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        flag_zero;
  logic        flag_carry;
  logic        op_illegal;

  logic        nm_in_valid;
  logic        nm_in_ready;
  logic        nm_out_valid;
  logic        nm_out_ready;
  logic [15:0] nm_result;
  logic [15:0] nm_result_hi;
  logic        nm_flag_zero;
  logic        nm_flag_carry;
  logic        nm_op_illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_WIDTH(16), .MUL_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func_code(func_code), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .op_illegal(op_illegal)
  );

  alu_exec_unit #(.DATA_WIDTH(16), .MUL_ENABLE(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .alu_op(alu_op), .func_code(func_code), .op_a(op_a), .op_b(op_b),
    .out_valid(nm_out_valid), .out_ready(nm_out_ready), .result(nm_result),
    .result_hi(nm_result_hi), .flag_zero(nm_flag_zero), .flag_carry(nm_flag_carry),
    .op_illegal(nm_op_illegal)
  );

  task automatic drive(input logic [3:0] op, input logic [3:0] fn,
                       input logic [15:0] a, input logic [15:0] b);
    alu_op    = op;
    func_code = fn;
    op_a      = a;
    op_b      = b;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if ({result, result_hi} !== 32'h0) begin failures++; $display("FAIL rst_result got=%h exp=00000000", {result, result_hi}); end
    checks++; if ({flag_zero, flag_carry, op_illegal} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {flag_zero, flag_carry, op_illegal}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_sub();
    drive(4'b0001, 4'b0000, 16'hFFFF, 16'h0001);
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, result} !== {1'b1, 16'h0000}) begin failures++; $display("FAIL add_res got=%b/%h exp=1/0000", out_valid, result); end
    checks++; if ({flag_zero, flag_carry} !== 2'b11) begin failures++; $display("FAIL add_flags got=%b exp=11", {flag_zero, flag_carry}); end
    drive(4'b0001, 4'b0001, 16'h0003, 16'h0005);
    @(negedge clk);
    checks++; if (result !== 16'hFFFE) begin failures++; $display("FAIL sub_res got=%h exp=fffe", result); end
    checks++; if ({flag_zero, flag_carry} !== 2'b01) begin failures++; $display("FAIL sub_flags got=%b exp=01", {flag_zero, flag_carry}); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sub_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_mul();
    int bad;
    bad = 0;
    drive(4'b0001, 4'b0100, 16'h1234, 16'h0100);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drive(4'b0001, 4'b0000, 16'hDEAD, 16'hBEEF);
    for (int i = 0; i < 16; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL mul_busy got=%0d bad cycles exp=0", bad); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mul_latency got=%b exp=1", out_valid); end
    checks++; if ({result_hi, result} !== 32'h0012_3400) begin failures++; $display("FAIL mul_res got=%h exp=00123400", {result_hi, result}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    drive(4'b0001, 4'b0100, 16'h0003, 16'h0005);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if ({result, result_hi, flag_zero, flag_carry, op_illegal} !== 35'h0) begin failures++; $display("FAIL midrst_outs got=%h/%h/%b exp=0", result, result_hi, {flag_zero, flag_carry, op_illegal}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    drive(4'b0001, 4'b0000, 16'h0001, 16'h0001);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, result} !== {1'b1, 16'h0002}) begin failures++; $display("FAIL midrst_add got=%b/%h exp=1/0002", out_valid, result); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    out_ready = 1'b0;
    drive(4'b0001, 4'b1111, 16'hAAAA, 16'h5555);
    in_valid = 1'b1;
    @(negedge clk);
    drive(4'b1001, 4'b0000, 16'hF0F0, 16'h0FF0);
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b1 || result !== 16'h5555 || result_hi !== 16'hAAAA || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, result, result_hi} !== {1'b1, 16'h00F0, 16'h0000}) begin failures++; $display("FAIL bp_and got=%b/%h/%h exp=1/00f0/0000", out_valid, result, result_hi); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    drive(4'b0001, 4'b0111, 16'h1234, 16'h0001);
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, op_illegal, result, result_hi} !== {2'b11, 32'h0}) begin failures++; $display("FAIL illegal got=%b/%b/%h/%h exp=1/1/0000/0000", out_valid, op_illegal, result, result_hi); end
    checks++; if (flag_carry !== 1'b0) begin failures++; $display("FAIL illegal_carry got=%b exp=0", flag_carry); end
    drive(4'b0110, 4'b0000, 16'h0010, 16'h0004);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({op_illegal, result} !== {1'b0, 16'h0014}) begin failures++; $display("FAIL default_add got=%b/%h exp=0/0014", op_illegal, result); end
    @(negedge clk);
  endtask

  task automatic test_mul_disabled();
    drive(4'b0001, 4'b0100, 16'h0003, 16'h0005);
    nm_in_valid = 1'b1;
    @(negedge clk);
    nm_in_valid = 1'b0;
    checks++; if ({nm_out_valid, nm_op_illegal, nm_result, nm_result_hi} !== {2'b11, 32'h0}) begin failures++; $display("FAIL nomul got=%b/%b/%h/%h exp=1/1/0000/0000", nm_out_valid, nm_op_illegal, nm_result, nm_result_hi); end
    @(negedge clk);
    checks++; if (nm_out_valid !== 1'b0) begin failures++; $display("FAIL nomul_drain got=%b exp=0", nm_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  t_op [8] = '{4'b0001, 4'b0001, 4'b1001, 4'b1010, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    logic [3:0]  t_fn [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1110, 4'b1111, 4'b0000, 4'b0000};
    logic [15:0] t_a  [8] = '{16'h0005, 16'h0010, 16'h00FF, 16'hF000, 16'h1111, 16'h1234, 16'h0100, 16'h7FFF};
    logic [15:0] t_b  [8] = '{16'h0003, 16'h0001, 16'h0F0F, 16'h000F, 16'h2222, 16'hABCD, 16'h0020, 16'h0001};
    logic [15:0] t_r  [8] = '{16'h0008, 16'h000F, 16'h000F, 16'hF00F, 16'h2222, 16'hABCD, 16'h0120, 16'h8000};
    logic [15:0] t_h  [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(t_op[i], t_fn[i], t_a[i], t_b[i]);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
      @(negedge clk);
      checks++; if ({out_valid, result, result_hi} !== {1'b1, t_r[i], t_h[i]}) begin failures++; $display("FAIL b2b_res[%0d] got=%b/%h/%h exp=1/%h/%h", i, out_valid, result, result_hi, t_r[i], t_h[i]); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    nm_in_valid  = 1'b0;
    out_ready    = 1'b1;
    nm_out_ready = 1'b1;
    drive(4'b0000, 4'b0000, 16'h0000, 16'h0000);
    test_reset();
    test_add_sub();
    test_mul();
    test_reset_mid_mul();
    test_backpressure();
    test_illegal();
    test_mul_disabled();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
